adc_frame_switch: RTL and testbench
===================================

# adc_frame_switch

Parametrised successor to the ADC/VGA/memory mode switch. It replaces clock muxing with a single clock and enables, and adds an internal frame buffer. The block routes ADC samples either live to the VGA path, into a one-shot frame capture buffer, or plays the captured frame back to VGA on pixel request. Mode changes take effect only at frame boundaries. It sits between the ADC front end and the VGA pixel pipeline.

## Interface
- DATA_W, 14, sample width
- DEPTH, 1024, buffer words (≥2; not required to be a power of 2); AW = clog2(DEPTH) is a local parameter
- CLK100  in  1  sole clock; all logic rising-edge
- RST_N  in  1  asynchronous, active-low reset
- MODE  in  2  requested mode: 00 live, 01 capture, 10 playback, 11 treated as live
- FRAME_SYNC  in  1  single-cycle pulse at frame start
- ADC_INPUT  in  DATA_W  sample
- ADC_VALID  in  1  sample strobe
- VGA_REQ  in  1  pixel request (playback)
- ADC_VGA  out  DATA_W  pixel data to VGA
- VGA_VALID  out  1  ADC_VGA qualifier
- CAPTURE_DONE  out  1  buffer holds a complete frame
- SHORT_FRAME  out  1  sticky: a capture was cut short by FRAME_SYNC
- STATE  out  2  00 LIVE, 01 CAPT, 10 HELD, 11 PLAY

## Operation
- MODE is sampled only on a cycle with FRAME_SYNC=1. Between syncs, MODE changes are ignored.
- LIVE: ADC_VGA is ADC_INPUT registered when ADC_VALID=1. VGA_VALID is ADC_VALID delayed one cycle. The buffer is untouched.
- LIVE → CAPT on sync with MODE=01: wr_ptr←0, CAPTURE_DONE←0.
- CAPT: each ADC_VALID writes buf[wr_ptr] and increments wr_ptr. The live passthrough to VGA continues unchanged.
  - The write at wr_ptr=DEPTH-1 sets CAPTURE_DONE=1, clears SHORT_FRAME, and moves to HELD.
  - Sync before the buffer is full: SHORT_FRAME←1. With MODE=01, wr_ptr←0 and capture restarts. With any other MODE, move to that mode's state with CAPTURE_DONE=0.
- HELD: the buffer is frozen and further ADC_VALID is ignored. Live passthrough continues.
  - Sync with MODE=01: stay HELD (capture is one-shot).
  - To re-arm, leave capture mode and then re-enter it.
- Sync with MODE=10 (from any state): go to PLAY with rd_ptr←0.
  - PLAY: each VGA_REQ reads buf[rd_ptr], then rd_ptr increments and wraps DEPTH-1→0.
  - If CAPTURE_DONE=0, PLAY outputs ADC_VGA=0 with VGA_VALID per request.
  - ADC_VALID is ignored in PLAY.
  - Every sync with MODE=10 resets rd_ptr to 0.
- Sync with MODE=00/11: go to LIVE. CAPTURE_DONE is retained, so a held frame can be played later.
- Simultaneous FRAME_SYNC and ADC_VALID: the sample belongs to the new frame and is processed under the new mode (it is written at wr_ptr 0 when entering CAPT).
- Simultaneous FRAME_SYNC and VGA_REQ in PLAY: the read uses address 0.
- The buffer is a synchronous single-port-write/single-port-read RAM, inferred, with no reset on its contents.

## Timing
- Reset values: ADC_VGA=0, VGA_VALID=0, CAPTURE_DONE=0, SHORT_FRAME=0, STATE=LIVE, wr_ptr=rd_ptr=0.
- RST_N asserted mid-capture or mid-playback returns the block to reset values immediately. Buffer contents are then invalid because CAPTURE_DONE=0.
- All outputs are registered.
- Latency:
  - LIVE: 1 cycle ADC_VALID→VGA_VALID.
  - PLAY: 1 cycle VGA_REQ→VGA_VALID.
- The state change caused by a sync is visible on STATE one cycle after the sync.
- CAPTURE_DONE rises 1 cycle after the final write.
- Throughput: one sample per cycle for both write and read.

## Test plan
- Reset, then MODE=00 and ADC_VALID with ADC_INPUT=0x1234 → next cycle ADC_VGA=0x1234, VGA_VALID=1, STATE=00.
- DEPTH=8, MODE=01, sync, then 8 valid samples 1..8 → CAPTURE_DONE=1 one cycle after the 8th, STATE=HELD. A 9th sample leaves the buffer unchanged.
- After the previous scenario: MODE=10, sync, then 10 VGA_REQ → ADC_VGA sequence 1..8,1,2 (wrap), each 1 cycle after its request.
- MODE=01, sync, 5 samples, then sync with MODE=01 → SHORT_FRAME=1, CAPTURE_DONE=0, wr_ptr restarts. A full capture of 8 samples then clears SHORT_FRAME.
- Change MODE from 00 to 10 mid-frame without a sync → STATE stays LIVE and passthrough is unaffected. It changes only after the next sync.
- Assert RST_N=0 during PLAY at rd_ptr=5 → all outputs return to reset values. A subsequent PLAY with no new capture outputs zeros.

Source files
------------

// File: rtl/adc_frame_switch.sv
// ADC frame switch: routes ADC samples live to VGA, into a one-shot frame
// buffer, or plays the captured frame back to VGA on pixel request.
module adc_frame_switch #(
  parameter int DATA_W = 14,
  parameter int DEPTH  = 1024
) (
  input  logic              CLK100,
  input  logic              RST_N,
  input  logic [1:0]        MODE,
  input  logic              FRAME_SYNC,
  input  logic [DATA_W-1:0] ADC_INPUT,
  input  logic              ADC_VALID,
  input  logic              VGA_REQ,
  output logic [DATA_W-1:0] ADC_VGA,
  output logic              VGA_VALID,
  output logic              CAPTURE_DONE,
  output logic              SHORT_FRAME,
  output logic [1:0]        STATE
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_LIVE = 2'b00,
    S_CAPT = 2'b01,
    S_HELD = 2'b10,
    S_PLAY = 2'b11
  } state_e;

  state_e            state_q, state_d, eff_state;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_addr, rd_addr;
  logic              wr_en, rd_en, capt_start, play_start, live_en, capt_full;
  logic [DATA_W-1:0] live_q, live_d, rd_data_q;
  logic              sel_ram_q, sel_ram_d;
  logic              vga_valid_q, vga_valid_d;
  logic              done_q, done_d, short_q, short_d;
  logic [DATA_W-1:0] mem [DEPTH];

  // State register
  always_ff @(posedge CLK100 or negedge RST_N) begin
    if (!RST_N) state_q <= S_LIVE;
    else        state_q <= state_d;
  end

  // Next state: MODE is only honoured on a frame sync
  always_comb begin
    state_d = state_q;
    if (FRAME_SYNC) begin
      unique case (MODE)
        2'b01: begin
          if (state_q == S_HELD) state_d = S_HELD;
          else                   state_d = S_CAPT;
        end
        2'b10:   state_d = S_PLAY;
        default: state_d = S_LIVE;
      endcase
    end else if (state_q == S_CAPT && ADC_VALID && wr_ptr_q == LAST_ADDR) begin
      state_d = S_HELD;
    end
  end

  // Outputs / datapath. A sample or request arriving with a sync is handled
  // under the post-sync state, with its pointer forced to 0.
  always_comb begin
    eff_state  = FRAME_SYNC ? state_d : state_q;
    capt_start = FRAME_SYNC && (state_d == S_CAPT);
    play_start = FRAME_SYNC && (state_d == S_PLAY);
    live_en    = (eff_state != S_PLAY);

    wr_en    = ADC_VALID && (eff_state == S_CAPT);
    wr_addr  = capt_start ? '0 : wr_ptr_q;
    wr_ptr_d = wr_addr;
    if (wr_en) wr_ptr_d = (wr_addr == LAST_ADDR) ? '0 : wr_addr + AW'(1);
    capt_full = wr_en && (wr_addr == LAST_ADDR);

    rd_en    = VGA_REQ && (eff_state == S_PLAY);
    rd_addr  = play_start ? '0 : rd_ptr_q;
    rd_ptr_d = rd_addr;
    if (rd_en) rd_ptr_d = (rd_addr == LAST_ADDR) ? '0 : rd_addr + AW'(1);

    done_d = done_q;
    if (capt_start)     done_d = 1'b0;
    else if (capt_full) done_d = 1'b1;

    short_d = short_q;
    if (FRAME_SYNC && state_q == S_CAPT) short_d = 1'b1;
    else if (capt_full)                  short_d = 1'b0;

    vga_valid_d = live_en ? ADC_VALID : VGA_REQ;
    live_d      = live_q;
    sel_ram_d   = sel_ram_q;
    if (live_en && ADC_VALID) begin
      live_d    = ADC_INPUT;
      sel_ram_d = 1'b0;
    end else if (rd_en) begin
      // Without a complete frame, playback emits zeros via the live register
      if (done_q) begin
        sel_ram_d = 1'b1;
      end else begin
        live_d    = '0;
        sel_ram_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK100 or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      live_q      <= '0;
      sel_ram_q   <= 1'b0;
      vga_valid_q <= 1'b0;
      done_q      <= 1'b0;
      short_q     <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      live_q      <= live_d;
      sel_ram_q   <= sel_ram_d;
      vga_valid_q <= vga_valid_d;
      done_q      <= done_d;
      short_q     <= short_d;
    end
  end

  // Frame buffer: synchronous write and registered read, contents not reset
  always_ff @(posedge CLK100) begin
    if (wr_en)           mem[wr_addr] <= ADC_INPUT;
    if (rd_en && done_q) rd_data_q    <= mem[rd_addr];
  end

  assign ADC_VGA      = sel_ram_q ? rd_data_q : live_q;
  assign VGA_VALID    = vga_valid_q;
  assign CAPTURE_DONE = done_q;
  assign SHORT_FRAME  = short_q;
  assign STATE        = state_q;

endmodule

// File: tb/tb_adc_frame_switch.sv
// Bench for adc_frame_switch with an 8-word buffer: vector table plus
// hand-written capture / playback / reset sequences.
module tb_adc_frame_switch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic        frame_sync;
  logic [13:0] adc_input;
  logic        adc_valid;
  logic        vga_req;
  logic [13:0] adc_vga;
  logic        vga_valid;
  logic        capture_done;
  logic        short_frame;
  logic [1:0]  state;

  always #5 clk = ~clk;

  adc_frame_switch #(.DATA_W(14), .DEPTH(8)) dut (
    .CLK100(clk), .RST_N(rst_n), .MODE(mode), .FRAME_SYNC(frame_sync),
    .ADC_INPUT(adc_input), .ADC_VALID(adc_valid), .VGA_REQ(vga_req),
    .ADC_VGA(adc_vga), .VGA_VALID(vga_valid), .CAPTURE_DONE(capture_done),
    .SHORT_FRAME(short_frame), .STATE(state)
  );

  typedef struct {
    logic [13:0] data;
    logic        vv;
    logic        done;
    logic        short_f;
    logic [1:0]  st;
  } exp_t;

  typedef struct {
    logic [1:0]  mode;
    logic        sync;
    logic        valid;
    logic [13:0] din;
    logic        req;
    exp_t        e;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[7];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t mk(input logic [13:0] d, input logic vv, input logic dn,
                              input logic sh, input logic [1:0] st);
    exp_t e;
    e.data = d; e.vv = vv; e.done = dn; e.short_f = sh; e.st = st;
    return e;
  endfunction

  task automatic compare(input exp_t e, input string name);
    checks++;
    if (adc_vga !== e.data || vga_valid !== e.vv || capture_done !== e.done ||
        short_frame !== e.short_f || state !== e.st) begin
      errors++;
      $display("FAIL %s: got data=%h valid=%b done=%b short=%b state=%b, expected data=%h valid=%b done=%b short=%b state=%b",
               name, adc_vga, vga_valid, capture_done, short_frame, state,
               e.data, e.vv, e.done, e.short_f, e.st);
    end
  endtask

  task automatic cyc(input logic [1:0] m, input logic s, input logic v,
                     input logic [13:0] d, input logic r, input exp_t e,
                     input string name);
    mode = m; frame_sync = s; adc_valid = v; adc_input = d; vga_req = r;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      compare(sb.pop_front(), name);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; mode = 2'b00; frame_sync = 1'b0; adc_input = '0;
    adc_valid = 1'b0; vga_req = 1'b0;

    // mode, sync, valid, din, req, expected {data, valid, done, short, state}
    tbl[0] = '{2'b00, 1'b1, 1'b1, 14'h1234, 1'b0, mk(14'h1234, 1, 0, 0, 2'b00)};
    tbl[1] = '{2'b00, 1'b0, 1'b0, 14'h0000, 1'b0, mk(14'h1234, 0, 0, 0, 2'b00)};
    tbl[2] = '{2'b10, 1'b0, 1'b1, 14'h0ABC, 1'b0, mk(14'h0ABC, 1, 0, 0, 2'b00)};
    tbl[3] = '{2'b10, 1'b0, 1'b0, 14'h0000, 1'b1, mk(14'h0ABC, 0, 0, 0, 2'b00)};
    tbl[4] = '{2'b10, 1'b1, 1'b1, 14'h0111, 1'b0, mk(14'h0ABC, 0, 0, 0, 2'b11)};
    tbl[5] = '{2'b10, 1'b0, 1'b0, 14'h0000, 1'b1, mk(14'h0000, 1, 0, 0, 2'b11)};
    tbl[6] = '{2'b00, 1'b1, 1'b1, 14'h0222, 1'b0, mk(14'h0222, 1, 0, 0, 2'b00)};

    repeat (3) @(posedge clk);
    #1;
    compare(mk(14'h0, 0, 0, 0, 2'b00), "reset_values");
    #2 rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      cyc(tbl[i].mode, tbl[i].sync, tbl[i].valid, tbl[i].din, tbl[i].req,
          tbl[i].e, $sformatf("vec%0d", i));

    // Full capture of samples 1..8
    cyc(2'b01, 1, 1, 14'd1, 0, mk(14'd1, 1, 0, 0, 2'b01), "capt_first");
    for (int i = 2; i <= 8; i++)
      cyc(2'b01, 0, 1, 14'(i), 0,
          mk(14'(i), 1, (i == 8), 0, (i == 8) ? 2'b10 : 2'b01),
          $sformatf("capt_s%0d", i));
    cyc(2'b01, 0, 1, 14'd99, 0, mk(14'd99, 1, 1, 0, 2'b10), "held_ignore");
    cyc(2'b01, 1, 0, 14'd0, 0, mk(14'd99, 0, 1, 0, 2'b10), "held_one_shot");

    // Playback with wrap
    cyc(2'b10, 1, 0, 14'd0, 0, mk(14'd99, 0, 1, 0, 2'b11), "play_start");
    for (int k = 0; k < 10; k++)
      cyc(2'b10, 0, 0, 14'd0, 1, mk(14'((k % 8) + 1), 1, 1, 0, 2'b11),
          $sformatf("play_r%0d", k));
    cyc(2'b10, 0, 1, 14'h3FFF, 0, mk(14'd2, 0, 1, 0, 2'b11), "play_adc_ignored");
    cyc(2'b10, 1, 0, 14'd0, 1, mk(14'd1, 1, 1, 0, 2'b11), "sync_req_addr0");
    cyc(2'b00, 1, 0, 14'd0, 0, mk(14'd1, 0, 1, 0, 2'b00), "live_retain_done");

    // Short frame then a full restart capture
    cyc(2'b01, 1, 1, 14'h10, 0, mk(14'h10, 1, 0, 0, 2'b01), "rearm_capt");
    for (int i = 1; i <= 4; i++)
      cyc(2'b01, 0, 1, 14'(16 + i), 0, mk(14'(16 + i), 1, 0, 0, 2'b01),
          $sformatf("short_s%0d", i));
    cyc(2'b01, 1, 1, 14'h20, 0, mk(14'h20, 1, 0, 1, 2'b01), "short_restart");
    for (int i = 1; i <= 7; i++)
      cyc(2'b01, 0, 1, 14'(32 + i), 0,
          mk(14'(32 + i), 1, (i == 7), (i != 7), (i == 7) ? 2'b10 : 2'b01),
          $sformatf("recapt_s%0d", i));

    // Playback of the restarted frame, stopping at rd_ptr = 5
    cyc(2'b10, 1, 0, 14'd0, 0, mk(14'h27, 0, 1, 0, 2'b11), "play2_start");
    for (int k = 0; k < 13; k++)
      cyc(2'b10, 0, 0, 14'd0, 1, mk(14'(32 + (k % 8)), 1, 1, 0, 2'b11),
          $sformatf("play2_r%0d", k));

    vga_req = 1'b0;
    #2 rst_n = 1'b0;
    #1 compare(mk(14'h0, 0, 0, 0, 2'b00), "async_reset_mid_play");
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Capture aborted to LIVE, then playback without a complete frame
    cyc(2'b01, 1, 1, 14'd5, 0, mk(14'd5, 1, 0, 0, 2'b01), "abort_capt0");
    cyc(2'b01, 0, 1, 14'd6, 0, mk(14'd6, 1, 0, 0, 2'b01), "abort_capt1");
    cyc(2'b00, 1, 1, 14'd7, 0, mk(14'd7, 1, 0, 1, 2'b00), "capt_abort_live");
    cyc(2'b10, 1, 0, 14'd0, 0, mk(14'd7, 0, 0, 1, 2'b11), "play3_start");
    cyc(2'b10, 0, 0, 14'd0, 1, mk(14'd0, 1, 0, 1, 2'b11), "play_no_capture");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
